// File: rtl/t_trans_pipe.sv
// Quaternary transfer stage: per-digit transfer/residual of a+b, optional segment split, LAT-deep valid/ready pipe.
// Optional saturating transfer-digit counter (stat_cnt) enabled by T_TRANS_PIPE_STAT_EN.
module t_trans_pipe #(
    parameter int         P     = 32,
    parameter int         SEGW  = 8,
    parameter int         LAT   = 2,
    parameter logic [1:0] TFILL = 2'b00,
    localparam int        NSEG  = P / SEGW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_split,
    input  logic [2*P-1:0]    a,
    input  logic [2*P-1:0]    b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*P+1:0]    t,
    output logic [2*P-1:0]    w,
    output logic [NSEG-1:0]   cout
`ifdef T_TRANS_PIPE_STAT_EN
    ,
    output logic [15:0]       stat_cnt
`endif
);

    typedef struct packed {
        logic [2*P+1:0]  t;
        logic [2*P-1:0]  w;
        logic [NSEG-1:0] cout;
    } res_t;

    logic [P-1:0]    tr;
    logic [2*P+1:0]  t_d;
    logic [2*P-1:0]  w_d;
    logic [NSEG-1:0] cout_d;
    res_t            res_d;

    // Digit sum is at most 6, so bit 2 of the 3-bit sum is exactly "sum >= 4".
    for (genvar i = 0; i < P; i++) begin : g_dig
        logic [2:0] sum;
        assign sum                = {1'b0, a[2*i +: 2]} + {1'b0, b[2*i +: 2]};
        assign tr[i]              = sum[2];
        assign w_d[2*i +: 2]      = sum[1:0];
    end

    for (genvar j = 0; j < NSEG; j++) begin : g_cout
        assign cout_d[j] = tr[j*SEGW + SEGW - 1];
    end

    always_comb begin
        t_d      = '0;
        t_d[1:0] = TFILL;
        for (int i = 0; i < P; i++) begin
            t_d[2*i + 2 +: 2] = {1'b0, tr[i]};
        end
        // Segment boundaries swallow the transfer from the segment below.
        if (in_split) begin
            for (int j = 1; j < NSEG; j++) begin
                t_d[2*j*SEGW +: 2] = TFILL;
            end
        end
    end

    assign res_d = {t_d, w_d, cout_d};

    logic [LAT-1:0] v_q;
    logic [LAT-1:0] ld;
    logic [LAT-1:0] v_in;
    res_t           dat_q [LAT];
    res_t           d_in  [LAT];

    // A stage may load if it or any stage above it is empty, or the sink drains.
    for (genvar k = 0; k < LAT; k++) begin : g_stg
        assign ld[k] = out_ready | ~(&v_q[LAT-1:k]);
        if (k == 0) begin : g_first
            assign v_in[k] = in_valid;
            assign d_in[k] = res_d;
        end else begin : g_next
            assign v_in[k] = v_q[k-1];
            assign d_in[k] = dat_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int k = 0; k < LAT; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LAT; k++) begin
                if (ld[k]) begin
                    v_q[k] <= v_in[k];
                    if (v_in[k]) begin
                        dat_q[k] <= d_in[k];
                    end
                end
            end
        end
    end

    assign in_ready        = ld[0];
    assign out_valid       = v_q[LAT-1];
    assign {t, w, cout}    = dat_q[LAT-1];

`ifdef T_TRANS_PIPE_STAT_EN
    localparam int CW = $clog2(P + 1);

    logic [15:0]   stat_q;
    logic [15:0]   stat_d;
    logic [CW-1:0] ntr;
    logic [16:0]   stat_sum;

    always_comb begin
        ntr = '0;
        for (int i = 0; i < P; i++) begin
            ntr = ntr + CW'(tr[i]);
        end
        stat_sum = {1'b0, stat_q} + 17'(ntr);
        stat_d   = stat_sum[16] ? 16'hFFFF : stat_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else if (in_valid && in_ready) begin
            stat_q <= stat_d;
        end
    end

    assign stat_cnt = stat_q;
`endif

endmodule
